// File: rtl/vc_fifo_buffer_pkg.sv
// Shared constants and types for the multi-VC router input buffer.
package vc_fifo_buffer_pkg;

    localparam int TAM_FLIT       = 8;
    localparam int TAM_BUFFER     = 4;
    localparam int NUM_VC_DEFAULT = 2;

    // Per-VC queue operation, encoded as {inc, dec}.
    typedef enum logic [1:0] {
        Q_HOLD = 2'b00,
        Q_POP  = 2'b01,
        Q_PUSH = 2'b10,
        Q_BOTH = 2'b11
    } q_op_e;

endpackage

// File: rtl/vc_fifo_buffer_queue_ctrl.sv
// Pointer and occupancy bookkeeping for one virtual channel, plus its occupancy checker.
module vc_queue_ctrl
    import vc_fifo_buffer_pkg::*;
#(
    parameter int DEPTH     = TAM_BUFFER,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int CW        = $clog2(DEPTH) + 1,
    parameter int PW        = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          afull
);

    logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          full_r, empty_r, afull_r;

    function automatic logic [PW-1:0] ptr_wrap(input logic [PW-1:0] p);
        ptr_wrap = (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Next pointers and occupancy from the inc/dec strobes.
    always_comb begin
        wr_nxt_s    = wr_ptr_r;
        rd_nxt_s    = rd_ptr_r;
        count_nxt_s = count_r;
        if (inc) begin
            wr_nxt_s = ptr_wrap(wr_ptr_r);
        end else begin
            wr_nxt_s = wr_ptr_r;
        end
        if (dec) begin
            rd_nxt_s = ptr_wrap(rd_ptr_r);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        case ({inc, dec})
            Q_PUSH:         count_nxt_s = count_r + CW'(1);
            Q_POP:          count_nxt_s = count_r - CW'(1);
            Q_HOLD, Q_BOTH: count_nxt_s = count_r;
            default:        count_nxt_s = count_r;
        endcase
    end

    // Status flags are registered alongside the count so they never lag it.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == CW'(DEPTH));
            empty_r  <= (count_nxt_s == {CW{1'b0}});
            afull_r  <= (count_nxt_s >= CW'(AFULL_LVL));
        end
    end

    assign wr_ptr = wr_ptr_r;
    assign rd_ptr = rd_ptr_r;
    assign count  = count_r;
    assign full   = full_r;
    assign empty  = empty_r;
    assign afull  = afull_r;

    vc_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clock (clock),
        .reset (reset),
        .count (count_r)
    );

endmodule

module vc_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clock,
    input logic          reset,
    input logic [CW-1:0] count
);

    a_count_range: assert property (@(posedge clock) disable iff (reset) count <= CW'(DEPTH));

endmodule

// File: rtl/vc_fifo_buffer.sv
// Multi-virtual-channel input buffer: NUM_VC circular flit queues sharing one storage array.
module vc_fifo_buffer
    import vc_fifo_buffer_pkg::*;
#(
    parameter int WIDTH     = TAM_FLIT,
    parameter int DEPTH     = TAM_BUFFER,
    parameter int NUM_VC    = NUM_VC_DEFAULT,
    parameter int AFULL_LVL = DEPTH - 1,
    localparam int VCW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CW       = $clog2(DEPTH) + 1,
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [VCW-1:0]       push_vc,
    input  logic [WIDTH-1:0]     tail,
    input  logic                 pull,
    input  logic [VCW-1:0]       pull_vc,
    output logic [NUM_VC*WIDTH-1:0] head_vec,
    output logic [NUM_VC*CW-1:0] counter_vec,
    output logic [NUM_VC-1:0]    empty_vec,
    output logic [NUM_VC-1:0]    full_vec,
    output logic [NUM_VC-1:0]    afull_vec,
    output logic [NUM_VC-1:0]    credit_vec,
    output logic                 overflow
);

    logic [WIDTH-1:0]  buff_r [NUM_VC][DEPTH];
    logic [PW-1:0]     wr_ptr_s [NUM_VC];
    logic [PW-1:0]     rd_ptr_s [NUM_VC];
    logic [NUM_VC-1:0] inc_s, dec_s;
    logic              push_in_range_s, pull_in_range_s;
    logic              push_ok_s, pull_ok_s, push_drop_s;
    logic [NUM_VC-1:0] credit_r;
    logic              overflow_r;

    assign push_in_range_s = ({1'b0, push_vc} < (VCW + 1)'(NUM_VC));
    assign pull_in_range_s = ({1'b0, pull_vc} < (VCW + 1)'(NUM_VC));

    // Request decode: a full VC still accepts a push when it is popped in the same cycle.
    always_comb begin
        pull_ok_s   = 1'b0;
        push_ok_s   = 1'b0;
        push_drop_s = 1'b0;
        inc_s       = {NUM_VC{1'b0}};
        dec_s       = {NUM_VC{1'b0}};
        if (!reset && pull && pull_in_range_s) begin
            pull_ok_s = !empty_vec[pull_vc];
        end else begin
            pull_ok_s = 1'b0;
        end
        if (!reset && push && push_in_range_s) begin
            if (!full_vec[push_vc] || (pull_ok_s && (pull_vc == push_vc))) begin
                push_ok_s = 1'b1;
            end else begin
                push_drop_s = 1'b1;
            end
        end else begin
            push_ok_s   = 1'b0;
            push_drop_s = 1'b0;
        end
        if (push_ok_s) begin
            inc_s[push_vc] = 1'b1;
        end else begin
            inc_s = {NUM_VC{1'b0}};
        end
        if (pull_ok_s) begin
            dec_s[pull_vc] = 1'b1;
        end else begin
            dec_s = {NUM_VC{1'b0}};
        end
    end

    genvar v;
    generate
        for (v = 0; v < NUM_VC; v++) begin : g_vc
            vc_queue_ctrl #(
                .DEPTH     (DEPTH),
                .AFULL_LVL (AFULL_LVL),
                .CW        (CW),
                .PW        (PW)
            ) u_ctrl (
                .clock  (clock),
                .reset  (reset),
                .inc    (inc_s[v]),
                .dec    (dec_s[v]),
                .wr_ptr (wr_ptr_s[v]),
                .rd_ptr (rd_ptr_s[v]),
                .count  (counter_vec[v*CW +: CW]),
                .full   (full_vec[v]),
                .empty  (empty_vec[v]),
                .afull  (afull_vec[v])
            );

            assign head_vec[v*WIDTH +: WIDTH] = buff_r[v][rd_ptr_s[v]];
        end
    endgenerate

    // Flit storage; contents are intentionally left uncleared by reset.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            buff_r[push_vc][wr_ptr_s[push_vc]] <= tail;
        end
    end

    // Upstream credit and drop reporting pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            credit_r   <= {NUM_VC{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            credit_r   <= dec_s;
            overflow_r <= push_drop_s;
        end
    end

    assign credit_vec = credit_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Directed bench: DEPTH=4 and DEPTH=3 buffers driven from one stimulus stream.
module tb_vc_fifo_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0, pull = 1'b0;
    logic [0:0]  push_vc = 1'b0, pull_vc = 1'b0;
    logic [7:0]  tail = 8'h00;

    logic [15:0] head4, head3;
    logic [5:0]  cnt4, cnt3;
    logic [1:0]  empty4, full4, afull4, credit4, empty3, full3, afull3, credit3;
    logic        ovf4, ovf3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    vc_fifo_buffer #(.WIDTH(8), .DEPTH(4), .NUM_VC(2)) d4 (
        .clock(clock), .reset(reset), .push(push), .push_vc(push_vc), .tail(tail),
        .pull(pull), .pull_vc(pull_vc), .head_vec(head4), .counter_vec(cnt4),
        .empty_vec(empty4), .full_vec(full4), .afull_vec(afull4),
        .credit_vec(credit4), .overflow(ovf4)
    );

    vc_fifo_buffer #(.WIDTH(8), .DEPTH(3), .NUM_VC(2)) d3 (
        .clock(clock), .reset(reset), .push(push), .push_vc(push_vc), .tail(tail),
        .pull(pull), .pull_vc(pull_vc), .head_vec(head3), .counter_vec(cnt3),
        .empty_vec(empty3), .full_vec(full3), .afull_vec(afull3),
        .credit_vec(credit3), .overflow(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given request; outputs are settled 1ns after the edge.
    task automatic step(input logic p, input logic pv, input logic [7:0] d,
                        input logic q, input logic qv);
        push = p; push_vc = pv; tail = d; pull = q; pull_vc = qv;
        @(posedge clock);
        #1;
        push = 1'b0; pull = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset then idle
        do_reset();
        check("rst_empty", empty4, 2'b11);
        check("rst_count", cnt4, 6'd0);
        check("rst_full", full4, 2'b00);
        check("rst_afull", afull4, 2'b00);
        check("rst_credit", credit4, 2'b00);
        check("rst_ovf", ovf4, 1'b0);
        check("rst_empty_d3", empty3, 2'b11);

        // 2: fill VC1 of the DEPTH=4 buffer
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
        check("fill3_afull", afull4, 2'b10);
        check("fill3_full", full4, 2'b00);
        step(1'b1, 1'b1, 8'hA4, 1'b0, 1'b0);
        check("fill_full", full4, 2'b10);
        check("fill_count", cnt4, 6'd32);
        check("fill_empty", empty4, 2'b01);
        step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        check("drop_ovf", ovf4, 1'b1);
        check("drop_count", cnt4, 6'd32);
        check("drop_head", head4[15:8], 8'hA1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_pulse_end", ovf4, 1'b0);

        // 3: push and pull on a full VC in the same cycle
        step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
        check("pp_head", head4[15:8], 8'hA2);
        check("pp_count", cnt4, 6'd32);
        check("pp_full", full4, 2'b10);
        check("pp_credit", credit4, 2'b10);
        check("pp_ovf", ovf4, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("credit_end", credit4, 2'b00);
        for (int i = 0; i < 4; i++) begin
            check("drain_head", head4[15:8], 8'hA2 + 8'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        end
        check("drain_empty", empty4, 2'b11);

        // 5: pull an empty VC0 while pushing VC1
        step(1'b1, 1'b1, 8'h5C, 1'b1, 1'b0);
        check("ep_count", cnt4, 6'd8);
        check("ep_empty", empty4, 2'b01);
        check("ep_credit", credit4, 2'b00);
        check("ep_head1", head4[15:8], 8'h5C);

        // 4: wrap on VC0 of the DEPTH=3 buffer
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0, 1'b0);
            check("wrap_cnt1", cnt3, 6'd1);
            check("wrap_head", head3[7:0], 8'h30 + 8'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_cnt0", cnt3, 6'd0);
            check("wrap_credit", credit3, 2'b01);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0, 1'b0);
        check("d3_full", full3, 2'b01);
        check("d3_head", head3[7:0], 8'h60);
        step(1'b1, 1'b0, 8'h63, 1'b0, 1'b0);
        check("d3_ovf", ovf3, 1'b1);
        check("d3_count", cnt3, 6'd3);

        // 6: reset with both VCs half full
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
            step(1'b1, 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        end
        check("half_count", cnt4, 6'd18);
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        check("mid_rst_count", cnt4, 6'd0);
        check("mid_rst_empty", empty4, 2'b11);
        step(1'b1, 1'b1, 8'h78, 1'b1, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_count", cnt4, 6'd0);
        check("post_rst_empty", empty4, 2'b11);
        check("post_rst_credit", credit4, 2'b00);
        check("post_rst_ovf", ovf4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
